conv1x1_stream_fp16: RTL and testbench
======================================

# conv1x1_stream_fp16

Parametrised, streaming float16 pointwise (1x1) convolution engine for the multi-channel conv layers. It accepts one pixel's D input channels serially over a valid/ready port and computes K output channels per pixel. Each output channel is one dot product over D, plus a per-channel bias, with optional ReLU. Outputs leave on a backpressured valid/ready port. Weights and biases are held in internal storage loaded through a write port, so the block is a bounded-cost replacement for flat-bus convolution when D, K and H×W are large.

## Interface
- D, 64, input channels per pixel (≥1)
- K, 64, output channels / filters (≥1)
- DATA_WIDTH, 16, element width; fixed at 16 (IEEE binary16)
- AW, $clog2(K*D+K), weight/bias write address width
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all control state and outputs
- w_we  in  1  weight/bias write strobe
- w_addr  in  AW  address: k*D+d for weight[k][d]; K*D+k for bias[k]
- w_data  in  16  fp16 value written
- relu_en  in  1  ReLU mode, sampled with the first input beat of each pixel
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept an input beat
- in_data  in  16  fp16 channel value, channel 0 first
- out_valid  out  1  output value valid
- out_ready  in  1  downstream accepts output
- out_data  out  16  fp16 result for channel k, k ascending
- out_last  out  1  high with out_valid on channel K-1
- busy  out  1  high in any state other than LOAD

## Operation
- FSM states: LOAD, COMPUTE, BIAS, OUT.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready beat stores in_data into pix[cnt_d], then cnt_d++.
  - relu_en is latched on beat 0.
  - The beat with cnt_d=D-1 moves the FSM to COMPUTE with k=0, d=0, acc=+0.
- COMPUTE: one MAC per cycle, acc ← acc + pix[d]·w[k][d]. On d=D-1, go to BIAS.
- BIAS:
  - r = acc + bias[k].
  - If relu latched and r[15]=1, out_data ← 0x0000; otherwise out_data ← r.
  - out_valid ← 1; go to OUT.
- OUT:
  - Hold out_data and out_valid until out_ready.
  - On handshake: if k<K-1, then k++, acc=+0, d=0, go to COMPUTE. Otherwise go to LOAD with cnt_d=0.
- Arithmetic:
  - Multiply and add in binary16, round toward zero.
  - Subnormal inputs and results are flushed to signed zero.
  - Overflow gives ±Inf.
  - NaN propagates. ReLU tests only the sign bit, so -0 and negative NaN both become 0x0000.
- Weight/bias writes:
  - Accepted only in LOAD with cnt_d=0; ignored otherwise (busy or partial pixel).
  - Addresses ≥ K*D+K are ignored.
  - Storage is not cleared by reset.
- Reset (any state, any time):
  - FSM→LOAD, cnt_d=k=d=0, acc=0.
  - out_valid=0, out_data=0x0000, out_last=0, busy=0, in_ready=1 after release.
  - Any partial pixel and pending output are discarded. Weights and biases are retained.

## Timing
- The final input beat is accepted at edge t. COMPUTE MACs occur at edges t+1..t+D. BIAS resolves at t+D+1, so out_valid=1 from t+D+1.
- With out_ready=1 the OUT state lasts one cycle. Each output channel costs D+2 cycles; a pixel costs D + K·(D+2) cycles including load.
- in_ready is 0 from the edge after the final input beat until the edge after the last out handshake.
- out_last is asserted only together with out_valid for k=K-1.
- While out_valid=1 and out_ready=0, out_data and out_last are stable and no state advances.
- Simultaneous w_we and the final input beat in LOAD: the write applies only if cnt_d=0 (i.e. D=1). It then lands before COMPUTE starts and is used by that pixel.

## Test plan
- D=4, K=2, all weights 0x4000, biases 0, inputs 0x3C00 → two outputs 0x4800; out_last only on the second; out_valid first high 5 edges after the last input beat.
- D=4, K=2, bias[1]=0xC900, same data: relu_en=0 → outputs 0x4800, 0xC000; relu_en=1 → 0x4800, 0x0000.
- Default D=64, K=64, weights 0x3C00, inputs 0x3C00, biases 0 → 64 outputs of 0x5400; first out_valid 65 edges after the last input; pixel period 64+64·66 cycles.
- out_ready held low 5 cycles during OUT → out_data/out_last stable, in_ready=0, next channel delayed exactly 5 cycles, no value lost or duplicated.
- Assert reset low mid-COMPUTE → out_valid=0, out_data=0x0000, busy=0 immediately. After release, in_ready=1, and the next pixel reproduces the expected results with the weights unchanged.
- w_we pulsed during COMPUTE/OUT and mid-LOAD with a changed weight → results match the old weights. The same write issued in LOAD with cnt_d=0 → the next pixel reflects the new weight.

Source files
------------

// File: rtl/conv1x1_stream_fp16.sv
// Streaming fp16 pointwise (1x1) convolution engine.
// One pixel of D channels is loaded serially, then K dot products
// (plus bias, optional ReLU) are produced one per output handshake.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   LOAD    | accept D input beats into the pixel buffer; weight writes open
//   COMPUTE | one MAC per cycle over d for the current output channel k
//   BIAS    | add bias[k], apply ReLU, present the result
//   OUT     | hold the result until the downstream handshake
module conv1x1_stream_fp16 #(
  parameter int D          = 64,
  parameter int K          = 64,
  parameter int DATA_WIDTH = 16,
  parameter int AW         = $clog2(K*D+K)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  w_we,
  input  logic [AW-1:0]         w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  relu_en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int NW = K*D + K;
  localparam int DW = (D > 1) ? $clog2(D) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_BIAS    = 2'd2,
    S_OUT     = 2'd3
  } state_t;

  // binary16 multiply, truncating; subnormals flush to signed zero
  function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
    logic              s;
    logic [21:0]       p;
    logic signed [7:0] e;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [15:0]       r;
    s      = a[15] ^ b[15];
    a_nan  = (a[14:10] == 5'h1f) && (a[9:0] != 10'd0);
    b_nan  = (b[14:10] == 5'h1f) && (b[9:0] != 10'd0);
    a_inf  = (a[14:10] == 5'h1f) && (a[9:0] == 10'd0);
    b_inf  = (b[14:10] == 5'h1f) && (b[9:0] == 10'd0);
    a_zero = (a[14:10] == 5'd0);
    b_zero = (b[14:10] == 5'd0);
    p      = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e      = $signed({3'b000, a[14:10]}) + $signed({3'b000, b[14:10]}) - 8'sd15
             + (p[21] ? 8'sd1 : 8'sd0);
    if (a_nan)                r = a | 16'h0200;
    else if (b_nan)           r = b | 16'h0200;
    else if (a_inf)           r = b_zero ? 16'h7E00 : {s, 5'h1f, 10'd0};
    else if (b_inf)           r = a_zero ? 16'h7E00 : {s, 5'h1f, 10'd0};
    else if (a_zero || b_zero) r = {s, 15'd0};
    else if (e >= 8'sd31)     r = {s, 5'h1f, 10'd0};
    else if (e <= 8'sd0)      r = {s, 15'd0};
    else                      r = {s, e[4:0], (p[21] ? p[20:11] : p[19:10])};
    return r;
  endfunction

  // binary16 add, exact in a wide fixed-point grid then truncated
  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    logic [40:0] fa, fb, mag;
    logic        s;
    logic        a_nan, b_nan, a_inf, b_inf;
    int          msb;
    logic [15:0] r;
    a_nan = (a[14:10] == 5'h1f) && (a[9:0] != 10'd0);
    b_nan = (b[14:10] == 5'h1f) && (b[9:0] != 10'd0);
    a_inf = (a[14:10] == 5'h1f) && (a[9:0] == 10'd0);
    b_inf = (b[14:10] == 5'h1f) && (b[9:0] == 10'd0);
    fa    = (a[14:10] == 5'd0) ? 41'd0 : (41'({1'b1, a[9:0]}) << (a[14:10] - 5'd1));
    fb    = (b[14:10] == 5'd0) ? 41'd0 : (41'({1'b1, b[9:0]}) << (b[14:10] - 5'd1));
    mag   = '0;
    s     = 1'b0;
    msb   = 0;
    r     = '0;
    if (a_nan)                              r = a | 16'h0200;
    else if (b_nan)                         r = b | 16'h0200;
    else if (a_inf && b_inf && (a[15] != b[15])) r = 16'h7E00;
    else if (a_inf)                         r = a;
    else if (b_inf)                         r = b;
    else begin
      if (a[15] == b[15]) begin
        mag = fa + fb;
        s   = a[15];
      end else if (fa >= fb) begin
        mag = fa - fb;
        s   = a[15];
      end else begin
        mag = fb - fa;
        s   = b[15];
      end
      for (int i = 0; i < 41; i++) begin
        if (mag[i]) msb = i;
      end
      // exact cancellation of opposite signs yields +0
      if (mag == 41'd0)   r = {(a[15] == b[15]) ? s : 1'b0, 15'd0};
      else if (msb >= 40) r = {s, 5'h1f, 10'd0};
      else if (msb < 10)  r = {s, 15'd0};
      else                r = {s, 5'(msb - 9), 10'(mag >> (msb - 10))};
    end
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   d_q, d_d;
  logic [KW-1:0]   k_q, k_d;
  logic [15:0]     acc_q, acc_d;
  logic            relu_q, relu_d;
  logic            out_valid_q, out_valid_d;
  logic [15:0]     out_data_q, out_data_d;
  logic            out_last_q, out_last_d;

  logic [15:0]     pix_mem [D];
  logic [15:0]     wb_mem  [NW];

  logic [AW-1:0]   w_idx, b_idx;
  logic [15:0]     prod, biased;
  logic            in_fire, wr_ok;

  assign in_ready  = (state_q == S_LOAD);
  assign busy      = (state_q != S_LOAD);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

  assign in_fire = in_valid && in_ready;
  assign wr_ok   = w_we && (state_q == S_LOAD) && (cnt_q == '0)
                   && ({1'b0, w_addr} < (AW+1)'(NW));
  assign w_idx   = AW'(k_q) * AW'(D) + AW'(d_q);
  assign b_idx   = AW'(K*D) + AW'(k_q);

  // next-state and datapath updates for the sequencing FSM
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    d_d         = d_q;
    k_d         = k_q;
    acc_d       = acc_q;
    relu_d      = relu_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    prod        = fp_mul(pix_mem[d_q], wb_mem[w_idx]);
    biased      = fp_add(acc_q, wb_mem[b_idx]);
    case (state_q)
      S_LOAD: begin
        if (in_fire) begin
          if (cnt_q == '0) relu_d = relu_en;
          if (cnt_q == DW'(D-1)) begin
            state_d = S_COMPUTE;
            cnt_d   = '0;
            k_d     = '0;
            d_d     = '0;
            acc_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        acc_d = fp_add(acc_q, prod);
        if (d_q == DW'(D-1)) state_d = S_BIAS;
        else                 d_d     = d_q + 1'b1;
      end
      S_BIAS: begin
        out_data_d  = (relu_q && biased[15]) ? 16'h0000 : biased;
        out_valid_d = 1'b1;
        out_last_d  = (k_q == KW'(K-1));
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (k_q != KW'(K-1)) begin
            k_d     = k_q + 1'b1;
            d_d     = '0;
            acc_d   = '0;
            state_d = S_COMPUTE;
          end else begin
            cnt_d   = '0;
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // control and output registers, cleared by the async reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      d_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      relu_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      d_q         <= d_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      relu_q      <= relu_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // pixel buffer and weight/bias storage; deliberately not reset
  always_ff @(posedge clk) begin
    if (in_fire) pix_mem[cnt_q] <= in_data;
    if (wr_ok)   wb_mem[w_addr] <= w_data;
  end

endmodule

// File: tb/tb_conv1x1_stream_fp16.sv
// Directed bench: a D=4/K=2 instance for function and timing corners,
// plus a default-size instance for the large-pixel throughput case.
module tb_conv1x1_stream_fp16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // small instance signals
  logic        s_w_we, s_relu, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last, s_busy;
  logic [3:0]  s_w_addr;
  logic [15:0] s_w_data, s_in_data, s_out_data;

  // default instance signals
  logic        b_w_we, b_relu, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_busy;
  logic [12:0] b_w_addr;
  logic [15:0] b_w_data, b_in_data, b_out_data;

  conv1x1_stream_fp16 #(.D(4), .K(2)) u_small (
    .clk(clk), .reset(reset), .w_we(s_w_we), .w_addr(s_w_addr), .w_data(s_w_data),
    .relu_en(s_relu), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_last(s_out_last), .busy(s_busy)
  );

  conv1x1_stream_fp16 u_big (
    .clk(clk), .reset(reset), .w_we(b_w_we), .w_addr(b_w_addr), .w_data(b_w_data),
    .relu_en(b_relu), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .busy(b_busy)
  );

  logic [15:0] s_wt  [10];
  logic [15:0] s_pix [4];
  logic [15:0] s_res [2];
  logic        s_lst [2];
  int          s_at  [2];
  int          s_tot;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic s_wr(input logic [3:0] a, input logic [15:0] v);
    s_w_we = 1'b1; s_w_addr = a; s_w_data = v;
    @(posedge clk); #1;
    s_w_we = 1'b0;
  endtask

  task automatic s_wr_all();
    for (int i = 0; i < 10; i++) s_wr(4'(i), s_wt[i]);
  endtask

  task automatic s_send(input logic relu, input bit mid_wr);
    for (int i = 0; i < 4; i++) begin
      s_in_valid = 1'b1; s_in_data = s_pix[i]; s_relu = relu;
      @(posedge clk); #1;
      if (i == 0 && mid_wr) begin
        s_in_valid = 1'b0;
        s_wr(4'd0, 16'h4400);
      end
    end
    s_in_valid = 1'b0;
  endtask

  task automatic s_collect(input int stall, input bit out_wr, input logic [15:0] e0);
    int n;
    s_tot = 0;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!s_out_valid && n < 200) begin
        @(posedge clk); #1; n++; s_tot++;
      end
      check("s_valid_wait", n < 200, 1);
      s_at[k]  = s_tot;
      s_res[k] = s_out_data;
      s_lst[k] = s_out_last;
      if (k == 0 && stall > 0) begin
        s_out_ready = 1'b0;
        for (int j = 0; j < stall; j++) begin
          @(posedge clk); #1; s_tot++;
          check("stall_data", s_out_data, e0);
          check("stall_last", s_out_last, 0);
          check("stall_valid", s_out_valid, 1);
          check("stall_in_ready", s_in_ready, 0);
        end
        s_out_ready = 1'b1;
      end
      if (k == 0 && out_wr) begin
        s_w_we = 1'b1; s_w_addr = 4'd0; s_w_data = 16'h4400;
      end
      @(posedge clk); #1; s_tot++;
      s_w_we = 1'b0;
    end
  endtask

  task automatic s_pixel(input logic relu, input logic [15:0] e0, input logic [15:0] e1, input string tag);
    s_send(relu, 1'b0);
    check({tag, "_in_ready_busy"}, {s_in_ready, s_busy}, 2'b01);
    s_collect(0, 1'b0, e0);
    check({tag, "_out0"}, s_res[0], e0);
    check({tag, "_out1"}, s_res[1], e1);
    check({tag, "_last"}, {s_lst[0], s_lst[1]}, 2'b01);
    check({tag, "_in_ready_after"}, s_in_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, tot;
    reset = 1'b0;
    s_w_we = 0; s_w_addr = 0; s_w_data = 0; s_relu = 0; s_in_valid = 0; s_in_data = 0; s_out_ready = 1;
    b_w_we = 0; b_w_addr = 0; b_w_data = 0; b_relu = 0; b_in_valid = 0; b_in_data = 0; b_out_ready = 1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("rst_out_valid", s_out_valid, 0);
    check("rst_out_data", s_out_data, 16'h0000);
    check("rst_out_last", s_out_last, 0);
    check("rst_busy", s_busy, 0);
    check("rst_in_ready", s_in_ready, 1);
    check("rst_big_busy_ready", {b_busy, b_in_ready}, 2'b01);

    // weights 2.0, biases 0, inputs 1.0 -> 8.0 per channel
    s_wt  = '{16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h0000, 16'h0000};
    s_pix = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
    s_wr_all();
    s_pixel(1'b0, 16'h4800, 16'h4800, "basic");
    check("basic_lat0", s_at[0], 5);
    check("basic_lat1", s_at[1], 11);

    // bias[1] = -10 -> 8-10 = -2, and ReLU clamps it
    s_wr(4'd9, 16'hC900);
    s_pixel(1'b0, 16'h4800, 16'hC000, "bias");
    s_pixel(1'b1, 16'h4800, 16'h0000, "relu");

    // 5-cycle backpressure on channel 0
    s_send(1'b0, 1'b0);
    s_collect(5, 1'b0, 16'h4800);
    check("stall_out0", s_res[0], 16'h4800);
    check("stall_out1", s_res[1], 16'hC000);
    check("stall_lat0", s_at[0], 5);
    check("stall_lat1", s_at[1], 16);

    // async reset in COMPUTE
    s_send(1'b0, 1'b0);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("midrst_out_valid", s_out_valid, 0);
    check("midrst_out_data", s_out_data, 16'h0000);
    check("midrst_busy", s_busy, 0);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", s_in_ready, 1);
    s_pixel(1'b0, 16'h4800, 16'hC000, "postrst");

    // async reset while a result is pending in OUT
    s_send(1'b0, 1'b0);
    s_out_ready = 1'b0;
    n = 0;
    while (!s_out_valid && n < 200) begin @(posedge clk); #1; n++; end
    check("outrst_wait", s_out_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("outrst_out_valid", s_out_valid, 0);
    check("outrst_out_data", s_out_data, 16'h0000);
    #2 reset = 1'b1;
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_pixel(1'b0, 16'h4800, 16'hC000, "postrst2");

    // writes while busy or mid-pixel are dropped
    s_send(1'b0, 1'b1);
    s_wr(4'd0, 16'h4400);
    s_collect(0, 1'b1, 16'h4800);
    check("blocked_out0", s_res[0], 16'h4800);
    check("blocked_out1", s_res[1], 16'hC000);
    // same write while idle takes effect: 4+2+2+2 = 10
    s_wr(4'd0, 16'h4400);
    s_pixel(1'b0, 16'h4900, 16'hC000, "newwt");

    // truncation, subnormal flush, overflow to Inf
    s_wt  = '{16'h3C01, 16'hBC00, 16'h3C00, 16'h3800, 16'h7BFF, 16'h7BFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    s_pix = '{16'h3C01, 16'h1000, 16'h0001, 16'h0400};
    s_wr_all();
    s_pixel(1'b0, 16'h3C01, 16'h7C00, "arith");

    // exact cancellation to +0; negative NaN propagates, ReLU zeroes it
    s_wt  = '{16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h3C00, 16'hFE00, 16'h3C00, 16'h3C00, 16'hC800, 16'h0000};
    s_pix = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
    s_wr_all();
    s_send(1'b0, 1'b0);
    s_collect(0, 1'b0, 16'h0000);
    check("cancel_out0", s_res[0], 16'h0000);
    check("nan_out1", {s_res[1][15], s_res[1][14:10] == 5'h1f, s_res[1][9:0] != 10'd0}, 3'b111);
    s_pixel(1'b1, 16'h0000, 16'h0000, "nanrelu");

    // default size: weights 1.0, biases 0, inputs 1.0 -> 64.0
    for (int i = 0; i < 64*64+64; i++) begin
      b_w_we = 1'b1; b_w_addr = 13'(i); b_w_data = (i < 64*64) ? 16'h3C00 : 16'h0000;
      @(posedge clk); #1;
    end
    b_w_we = 1'b0;
    for (int i = 0; i < 64; i++) begin
      b_in_valid = 1'b1; b_in_data = 16'h3C00;
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    tot = 0;
    for (int k = 0; k < 64; k++) begin
      n = 0;
      while (!b_out_valid && n < 500) begin @(posedge clk); #1; n++; tot++; end
      check("big_valid_wait", n < 500, 1);
      if (k == 0) check("big_lat0", tot, 65);
      check("big_out", b_out_data, 16'h5400);
      check("big_last", b_out_last, (k == 63));
      @(posedge clk); #1; tot++;
    end
    check("big_period", 64 + tot, 64 + 64*66);
    check("big_in_ready_after", b_in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
